// File: rtl/pwm.sv
// Counter-based PWM generator with a programmable prescaler.
// A prescale timer paces an R-bit duty counter; pwm_out is high while it is below duty.
module pwm #(
  parameter int R          = 8,
  parameter int TIMER_BITS = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [R:0]            duty,
  input  logic [TIMER_BITS-1:0] FINAL_VALUE,
  output logic                  pwm_out
);

  logic [TIMER_BITS-1:0] timer_q, timer_d;
  logic [R-1:0]          q_q, q_d;
  logic                  pwm_q, pwm_d;
  logic                  tick;

  // Next state: >= compare so a lowered terminal count restarts at once.
  always_comb begin
    tick    = (timer_q >= FINAL_VALUE);
    timer_d = timer_q + 1'b1;
    q_d     = q_q;
    if (tick) begin
      timer_d = '0;
      q_d     = q_q + 1'b1;
    end
    pwm_d = ({1'b0, q_q} < duty);
  end

  // State registers; reset (active-high despite the name) wins.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      timer_q <= '0;
      q_q     <= '0;
      pwm_q   <= 1'b0;
    end else begin
      timer_q <= timer_d;
      q_q     <= q_d;
      pwm_q   <= pwm_d;
    end
  end

  assign pwm_out = pwm_q;

endmodule

// File: tb/tb_pwm.sv
// Self-checking bench for pwm.
// Reference: step index = floor(edges/(FINAL_VALUE+1)) mod 256.
module tb_pwm;

  logic       clk;
  logic       reset_n;
  logic [8:0] duty;
  logic [7:0] FINAL_VALUE;
  logic       pwm_out;

  int compared;
  int mism;
  int n;
  int fv;
  int hi;
  int lo;

  pwm #(.R(8), .TIMER_BITS(8)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .duty        (duty),
    .FINAL_VALUE (FINAL_VALUE),
    .pwm_out     (pwm_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int qm(input int k);
    return (k / (fv + 1)) % 256;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mism++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic set_fv(input int v);
    fv          = v;
    FINAL_VALUE = 8'(v);
  endtask

  task automatic edge_raw();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b1;
    edge_raw();
    chk("rst_pwm", {31'd0, pwm_out}, 0);
    chk("rst_timer", {24'd0, dut.timer_q}, 0);
    chk("rst_q", {24'd0, dut.q_q}, 0);
    reset_n = 1'b0;
    n  = 0;
    hi = 0;
    lo = 0;
  endtask

  task automatic clk_edge();
    logic e;
    edge_raw();
    n++;
    e = (qm(n - 1) < int'(duty));
    chk("pwm", {31'd0, pwm_out}, {31'd0, e});
    if (pwm_out === 1'b1) hi++;
    else lo++;
  endtask

  task automatic run(input int cnt);
    for (int i = 0; i < cnt; i++) clk_edge();
  endtask

  initial begin
    compared = 0;
    mism     = 0;
    reset_n  = 1'b1;
    duty     = '0;
    set_fv(0);

    // Full period at FINAL_VALUE=194, duty=64
    set_fv(194);
    duty = 9'd64;
    do_reset();
    clk_edge();
    chk("first_rise", {31'd0, pwm_out}, 1);
    run(49919);
    chk("hi64", hi, 12480);
    chk("lo64", lo, 37440);

    // Duty switches at period boundaries, shorter step
    set_fv(3);
    duty = 9'd128;
    do_reset();
    run(1024);
    chk("hi128", hi, 512);
    chk("lo128", lo, 512);
    duty = 9'd192;
    hi = 0;
    lo = 0;
    run(1024);
    chk("hi192", hi, 768);
    chk("lo192", lo, 256);

    // FINAL_VALUE=0 extremes
    set_fv(0);
    duty = 9'd1;
    do_reset();
    run(256);
    chk("hi_d1", hi, 1);
    chk("lo_d1", lo, 255);
    duty = 9'd0;
    do_reset();
    run(256);
    chk("hi_d0", hi, 0);
    duty = 9'd256;
    do_reset();
    run(256);
    chk("wrap_q", {24'd0, dut.q_q}, 0);
    run(44);
    chk("hi_d256", hi, 300);
    duty = 9'd300;
    do_reset();
    run(300);
    chk("hi_d300", hi, 300);

    // Lowering FINAL_VALUE below the running count
    set_fv(200);
    duty = 9'd1;
    do_reset();
    run(100);
    chk("pre_timer", {24'd0, dut.timer_q}, 100);
    FINAL_VALUE = 8'd3;
    edge_raw();
    chk("low_timer", {24'd0, dut.timer_q}, 0);
    chk("low_q", {24'd0, dut.q_q}, 1);
    chk("low_pwm1", {31'd0, pwm_out}, 1);
    edge_raw();
    chk("low_pwm0", {31'd0, pwm_out}, 0);
    chk("low_t1", {24'd0, dut.timer_q}, 1);
    edge_raw();
    edge_raw();
    chk("low_q_hold", {24'd0, dut.q_q}, 1);
    chk("low_t3", {24'd0, dut.timer_q}, 3);
    edge_raw();
    chk("low_q2", {24'd0, dut.q_q}, 2);
    chk("low_t0", {24'd0, dut.timer_q}, 0);

    // Reset in the middle of a period
    set_fv(9);
    duty = 9'd128;
    do_reset();
    run(1300);
    do_reset();
    run(2560);
    chk("mid_hi", hi, 1280);
    chk("mid_lo", lo, 1280);

    // Random segments with duty changing on the fly
    for (int s = 0; s < 6; s++) begin
      set_fv(int'($urandom_range(0, 5)));
      duty = 9'($urandom_range(0, 300));
      do_reset();
      for (int i = 0; i < 600; i++) begin
        if ($urandom_range(0, 7) == 0)
          duty = 9'($urandom_range(0, 300));
        clk_edge();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mism);
    $finish;
  end

endmodule
